// File: rtl/div_unit.sv
// Multi-cycle restoring divider, signed or unsigned, returning {remainder, quotient}.
// Supports divide-by-zero detection and cancellation of an operation in flight.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     diff;
  logic                 fits;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  always_comb begin
    // The most negative value negates to itself and reads as an unsigned magnitude.
    a_mag    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_mag    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, dsr_q});
    diff     = shifted[WIDTH-1:0] - dsr_q;
    quot_fix = neg_quot_q ? -dvd_q : dvd_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          dvd_d      = a_mag;
          dsr_d      = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
          state_d    = (opdata2_i == '0) ? StByZero : StOn;
        end
      end
      StByZero: begin
        result_d = '0;
        if (annul_i) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end else begin
          ready_d = 1'b1;
          state_d = StEnd;
        end
      end
      StOn: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = StIdle;
        end else if (cnt_q == CntW'(WIDTH)) begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          state_d  = StEnd;
        end else begin
          rem_d = fits ? diff : shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEnd: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic reference model checked every cycle, plus directed
// literal cases and randomized operations with annuls and operand changes.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the answer at acceptance and counts edges until it is due.
  logic        m_ready;
  logic [63:0] m_result;
  logic        m_busy;
  int          m_left;
  logic [63:0] m_pending;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready  <= 1'b0;
      m_result <= 64'd0;
      m_busy   <= 1'b0;
      m_left   <= 0;
    end else if (m_ready) begin
      if (!start_i) begin
        m_ready  <= 1'b0;
        m_result <= 64'd0;
      end
    end else if (m_busy) begin
      if (annul_i) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_ready  <= 1'b1;
        m_result <= m_pending;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start_i && !annul_i) begin
      m_busy    <= 1'b1;
      m_left    <= (opdata2_i == 32'd0) ? 1 : 33;
      m_pending <= ref_div(signed_div_i, opdata1_i, opdata2_i);
    end
  end

  initial begin
    @(posedge rst);
    forever begin
      @(negedge clk);
      check("cycle ready", {63'd0, ready_o}, {63'd0, m_ready});
      check("cycle result", result_o, m_result);
    end
  end

  task automatic drive(input logic s, input logic an, input logic sg, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start_i      = s;
    annul_i      = an;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
  endtask

  // Counts negedges after the driving negedge; the first one follows the acceptance edge.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < 60) begin
      @(negedge clk);
      edges++;
      if (ready_o) break;
    end
  endtask

  task automatic op(input string name, input logic sg, input logic [31:0] a,
                    input logic [31:0] b, input logic [63:0] exp, input int lat);
    int e;
    drive(1'b1, 1'b0, sg, a, b);
    wait_ready(e);
    check({name, " latency"}, e, lat);
    check({name, " result"}, result_o, exp);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check({name, " drop ready"}, {63'd0, ready_o}, 64'd0);
    check({name, " drop result"}, result_o, 64'd0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      check(name, {63'd0, ready_o}, 64'd0);
    end
  endtask

  initial begin
    int e;
    logic [31:0] a, b;
    logic sg;
    int k;
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);

    check("model pin sdiv", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    check("model pin ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    op("udiv", 1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001_7FFFFFFF, 34);
    op("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
    op("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
    op("div0", 1'b0, 32'h12345678, 32'd0, 64'd0, 2);
    op("overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);

    // Annul partway through the loop.
    drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'd100, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_quiet("annul quiet", 40);
    op("after annul", 1'b0, 32'd100, 32'd3, 64'h00000001_00000021, 34);

    // Annul on the edge that would complete.
    drive(1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    repeat (32) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'd50, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    expect_quiet("late annul quiet", 5);

    // Start and annul together in IDLE.
    drive(1'b1, 1'b1, 1'b0, 32'd50, 32'd5);
    expect_quiet("start+annul quiet", 40);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset mid-ON, then again while a result is held.
    drive(1'b1, 1'b0, 1'b0, 32'd1000, 32'd7);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst on ready", {63'd0, ready_o}, 64'd0);
    check("rst on result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("post rst quiet", 40);
    drive(1'b1, 1'b0, 1'b0, 32'd1000, 32'd7);
    wait_ready(e);
    #2 rst = 1'b1;
    #1 check("rst end ready", {63'd0, ready_o}, 64'd0);
    check("rst end result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Operands and mode changed during ON, then result held in END.
    drive(1'b1, 1'b0, 1'b0, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFFFFFFF0);
    wait_ready(e);
    check("stable ops result", result_o, 64'h00000006_0000008E);
    repeat (5) begin
      @(negedge clk);
      check("end hold result", result_o, 64'h00000006_0000008E);
      check("end hold ready", {63'd0, ready_o}, 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 150; i++) begin
      a  = $urandom;
      b  = $urandom;
      sg = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, 9);
      case (k)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; sg = 1'b1; end
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      drive(1'b1, 1'b0, sg, a, b);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 36)) @(negedge clk);
        drive(1'b0, 1'b1, sg, a, b);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end else begin
        e = 0;
        while (e < 40 && !ready_o) begin
          @(negedge clk);
          e++;
          if ($urandom_range(0, 15) == 0) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~signed_div_i;
          end
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
